// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal TX FIFO.
//   Generates bit timing from clk (CLK_DIV clocks per bit), frames each word as
//   start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop
//   bits, and chains queued words back-to-back with no idle gap.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    word to transmit (push = in_valid & in_ready)
//   in_valid   in_data valid
//   in_ready   FIFO not full
//   tx         registered serial line, idle high
//   busy       frame in progress or FIFO non-empty
//   fifo_count words currently held in the FIFO
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state, state_nxt;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  logic                 tx_r, tx_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt, par_calc;
  logic                 baud_end;

  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign tx         = tx_r;
  assign busy       = (state != S_IDLE) | (count != '0);
  assign par_calc   = (PARITY == 1) ? ~(^head) : (^head);

  // FIFO storage is not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_r     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_r     <= tx_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
    end
  end

  // tx_nxt is the value the line takes for the next bit, so the line itself
  // stays a plain register. bit_cnt indexes data bits in DATA and stop bits in STOP.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_r;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;
    pop       = 1'b0;
    baud_end  = (baud_cnt == BAUD_LAST);

    if (state != S_IDLE) baud_nxt = baud_end ? '0 : baud_cnt + BW'(1);

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = head;
          par_nxt   = par_calc;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_nxt = S_DATA;
          tx_nxt    = shift[0];
          shift_nxt = shift >> 1;
          bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            tx_nxt    = shift[0];
            shift_nxt = shift >> 1;
            bit_nxt   = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (count != '0) begin
              pop       = 1'b1;
              shift_nxt = head;
              par_nxt   = par_calc;
              tx_nxt    = 1'b0;
              state_nxt = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four configurations driven from a shared bus,
// tx/busy/count checked every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [3:0] vld = '0;

  logic tx_a, tx_b, tx_c, tx_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic rdy_a, rdy_b, rdy_c, rdy_d;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b, cnt_c, cnt_d;

  // Configurations: 0 = 8N1 div4 depth16, 1 = 8E1 div4 depth4,
  //                 2 = 8O1 div4 depth4,  3 = 7N2 div3 depth4
  int div_c   [4] = '{4, 4, 4, 3};
  int dbits_c [4] = '{8, 8, 8, 7};
  int par_c   [4] = '{0, 2, 1, 0};
  int stops_c [4] = '{1, 1, 1, 2};
  int depth_c [4] = '{16, 4, 4, 4};

  int   sel = 0;
  logic cur_tx, cur_busy, cur_rdy;
  int   cur_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] wq  [16];
  int         off [16];
  int         e0;
  int         pushed;
  bit         started;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[0]), .in_ready(rdy_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[1]), .in_ready(rdy_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[2]), .in_ready(rdy_c),
    .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));
  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst(rst), .in_data(din[6:0]), .in_valid(vld[3]), .in_ready(rdy_d),
    .tx(tx_d), .busy(busy_d), .fifo_count(cnt_d));

  always_comb begin
    cur_tx = tx_a; cur_busy = busy_a; cur_rdy = rdy_a; cur_cnt = int'(cnt_a);
    case (sel)
      1: begin cur_tx = tx_b; cur_busy = busy_b; cur_rdy = rdy_b; cur_cnt = int'(cnt_b); end
      2: begin cur_tx = tx_c; cur_busy = busy_c; cur_rdy = rdy_c; cur_cnt = int'(cnt_c); end
      3: begin cur_tx = tx_d; cur_busy = busy_d; cur_rdy = rdy_d; cur_cnt = int'(cnt_d); end
      default: ;
    endcase
  end

  function automatic int frame_len(input int s);
    return (1 + dbits_c[s] + ((par_c[s] != 0) ? 1 : 0) + stops_c[s]) * div_c[s];
  endfunction

  // Bit number idx of the frame for word w: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input int s, input logic [7:0] w, input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= dbits_c[s]) return w[idx-1];
    if (par_c[s] != 0 && idx == dbits_c[s] + 1) begin
      for (int b = 0; b < dbits_c[s]; b++) if (w[b]) ones++;
      if (par_c[s] == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  // Pushes wq[0..n-1] (word i no earlier than edge e0+off[i]) and checks the
  // line as one continuous stream of frames starting one clock after the first push.
  task automatic run_stream(input int s, input int n, input string nm);
    int fl;
    fl = frame_len(s);
    sel = s; started = 0; pushed = 0; e0 = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int g;
          g = 0;
          forever begin
            @(negedge clk);
            if (cur_rdy && (i == 0 || cyc + 1 >= e0 + off[i])) break;
            g++;
            if (g > 5000) break;
          end
          if (g > 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s push_timeout word %0d: in_ready stayed 0, required 1", nm, i);
          end
          din = wq[i]; vld[s] = 1'b1;
          @(posedge clk); #1;
          vld[s] = 1'b0;
          pushed++;
          if (i == 0) begin e0 = cyc; started = 1; end
        end
      end
      begin
        int g;
        int ec;
        logic eb;
        g = 0;
        while (!started && g < 20000) begin @(negedge clk); g++; end
        n_cmp++;
        if (!started) begin
          n_bad++;
          $display("FAIL %s start_timeout: no push seen, required one", nm);
        end else begin
          if (cur_tx !== 1'b1) begin
            n_bad++;
            $display("FAIL %s latency_idle: tx=%b required 1", nm, cur_tx);
          end
          for (int i = 0; i < n; i++) begin
            for (int t = 0; t < fl; t++) begin
              @(negedge clk);
              eb = exp_bit(s, wq[i], t / div_c[s]);
              ec = pushed - (i + 1);
              n_cmp++;
              if (cur_tx !== eb) begin
                n_bad++;
                $display("FAIL %s tx word %0d clk %0d: got %b required %b", nm, i, t, cur_tx, eb);
              end
              n_cmp++;
              if (cur_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy word %0d clk %0d: got %b required 1", nm, i, t, cur_busy);
              end
              n_cmp++;
              if (cur_cnt != ec || cur_rdy !== (ec != depth_c[s])) begin
                n_bad++;
                $display("FAIL %s count word %0d clk %0d: got cnt=%0d rdy=%b required cnt=%0d rdy=%b",
                         nm, i, t, cur_cnt, cur_rdy, ec, ec != depth_c[s]);
              end
            end
          end
          @(negedge clk);
          n_cmp++;
          if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_cnt != 0) begin
            n_bad++;
            $display("FAIL %s end_idle: got tx=%b busy=%b cnt=%0d required 1 0 0",
                     nm, cur_tx, cur_busy, cur_cnt);
          end
        end
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      n_cmp++;
      if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_rdy !== 1'b1 || cur_cnt != 0) begin
        n_bad++;
        $display("FAIL reset cfg%0d: got tx=%b busy=%b rdy=%b cnt=%0d required 1 0 1 0",
                 s, cur_tx, cur_busy, cur_rdy, cur_cnt);
      end
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    wq[0] = 8'hA5; off[0] = 0;
    run_stream(0, 1, "8N1_A5");
  endtask

  task automatic test_parity();
    wq[0] = 8'h07; off[0] = 0;
    run_stream(1, 1, "even_07");
    run_stream(2, 1, "odd_07");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin wq[i] = 8'($urandom); off[i] = 0; end
    run_stream(1, 6, "b2b_depth4");
  endtask

  task automatic test_7n2();
    wq[0] = 8'h55; off[0] = 0;
    run_stream(3, 1, "7N2_55");
    for (int i = 0; i < 5; i++) begin wq[i] = 8'($urandom); off[i] = 0; end
    run_stream(3, 5, "7N2_rand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      wq[i]  = 8'($urandom);
      off[i] = (i == 0) ? 0 : int'($urandom_range(0, (i - 1) * frame_len(2)));
    end
    run_stream(2, 8, "odd_rand");
  endtask

  // Word 3 arrives on the very edge frame 1 ends, with two words queued.
  task automatic test_push_pop_same();
    for (int i = 0; i < 4; i++) wq[i] = 8'($urandom);
    off[0] = 0; off[1] = 1; off[2] = 2; off[3] = 1 + frame_len(0);
    run_stream(0, 4, "push_pop_same");
  endtask

  task automatic test_reset_mid();
    int  g;
    bit  bad;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      wq[i] = 8'($urandom);
      @(negedge clk); din = wq[i]; vld[0] = 1'b1;
      @(posedge clk); #1;
      if (i == 0) e0 = cyc;
    end
    vld[0] = 1'b0;
    g = 0;
    while (cyc < e0 + 18 && g < 100) begin @(negedge clk); g++; end
    n_cmp++;
    if (cur_tx !== wq[0][3] || cur_cnt != 2) begin
      n_bad++;
      $display("FAIL rst_mid pre: got tx=%b cnt=%0d required %b 2", cur_tx, cur_cnt, wq[0][3]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cur_tx !== 1'b1 || cur_cnt != 0 || cur_busy !== 1'b0 || cur_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid async: got tx=%b cnt=%0d busy=%b rdy=%b required 1 0 0 1",
               cur_tx, cur_cnt, cur_busy, cur_rdy);
    end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_cnt != 0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL rst_mid idle_after: line left idle, required tx=1 busy=0 cnt=0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_7n2();
    test_push_pop_same();
    test_reset_mid();
    test_basic();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
